// File: rtl/date_pkg.sv
// rtl/date_pkg.sv - shared field-select encoding and calendar helpers for the date counter
package date_pkg;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_YEAR  = 2'd1,
    SEL_MONTH = 2'd2,
    SEL_DAY   = 2'd3
  } date_sel_e;

  localparam logic [7:0] MONTH_JAN = 8'd1;
  localparam logic [7:0] MONTH_FEB = 8'd2;
  localparam logic [7:0] MONTH_APR = 8'd4;
  localparam logic [7:0] MONTH_JUN = 8'd6;
  localparam logic [7:0] MONTH_SEP = 8'd9;
  localparam logic [7:0] MONTH_NOV = 8'd11;
  localparam logic [7:0] MONTH_DEC = 8'd12;

  function automatic logic is_leap(input logic [15:0] y);
    return (y[1:0] == 2'b00) &&
           (((y % 16'd100) != 16'd0) || ((y % 16'd400) == 16'd0));
  endfunction

  function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic leap);
    case (m)
      MONTH_FEB:                               return leap ? 8'd29 : 8'd28;
      MONTH_APR, MONTH_JUN, MONTH_SEP, MONTH_NOV: return 8'd30;
      default:                                 return 8'd31;
    endcase
  endfunction

endpackage

// File: rtl/date_set.sv
// rtl/date_set.sv - field selector for date set mode, rotating year/month/day on shift
module date_set
  import date_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      set_date_en,
  input  logic      set_date_shift,
  output date_sel_e sel
);

  date_sel_e sel_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel <= SEL_NONE;
    else        sel <= sel_next;
  end

  always_comb begin
    sel_next = sel;
    if (!set_date_en) begin
      sel_next = SEL_NONE;
    end else begin
      case (sel)
        SEL_NONE:  sel_next = SEL_YEAR;
        SEL_YEAR:  if (set_date_shift) sel_next = SEL_MONTH;
        SEL_MONTH: if (set_date_shift) sel_next = SEL_DAY;
        SEL_DAY:   if (set_date_shift) sel_next = SEL_YEAR;
        default:   sel_next = SEL_NONE;
      endcase
    end
  end

endmodule

// File: rtl/date_counter.sv
// rtl/date_counter.sv - year/month/day calendar advanced by the time-of-day day carry, with set mode
module date_counter
  import date_pkg::*;
#(
  parameter int YEAR_MIN   = 2000,
  parameter int YEAR_MAX   = 2099,
  parameter int RESET_YEAR = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cout_day,
  input  logic        set_date_en,
  input  logic        set_date_shift,
  input  logic        set_date_add,
  output logic [15:0] out_year,
  output logic [7:0]  out_month,
  output logic [7:0]  out_day,
  output logic        leap_year,
  output logic [1:0]  blink2
);

  localparam logic [15:0] YMIN   = 16'(YEAR_MIN);
  localparam logic [15:0] YMAX   = 16'(YEAR_MAX);
  localparam logic [15:0] YRESET = 16'(RESET_YEAR);

  logic [15:0] year_q, year_n, year_inc;
  logic [7:0]  month_q, month_n, month_inc;
  logic [7:0]  day_q, day_n, dim_cur, dim_new;
  logic        cout_day_q, adv, add_act;
  logic [1:0]  blink_q;
  date_sel_e   sel;

  date_set u_date_set (
    .clk            (clk),
    .rst_n          (rst_n),
    .set_date_en    (set_date_en),
    .set_date_shift (set_date_shift),
    .sel            (sel)
  );

  // Carry is dropped, not deferred, while in set mode; the edge register keeps tracking.
  always_comb begin
    adv       = cout_day & ~cout_day_q & ~set_date_en;
    add_act   = set_date_add & set_date_en & (sel != SEL_NONE);
    year_inc  = (year_q >= YMAX) ? YMIN : year_q + 16'd1;
    month_inc = (month_q >= MONTH_DEC) ? MONTH_JAN : month_q + 8'd1;
    dim_cur   = days_in_month(month_q, is_leap(year_q));
    dim_new   = dim_cur;
    year_n    = year_q;
    month_n   = month_q;
    day_n     = day_q;
    if (adv) begin
      if (day_q < dim_cur) begin
        day_n = day_q + 8'd1;
      end else begin
        day_n   = 8'd1;
        month_n = month_inc;
        if (month_q >= MONTH_DEC) year_n = year_inc;
      end
    end else if (add_act) begin
      case (sel)
        SEL_YEAR: begin
          year_n  = year_inc;
          dim_new = days_in_month(month_q, is_leap(year_inc));
        end
        SEL_MONTH: begin
          month_n = month_inc;
          dim_new = days_in_month(month_inc, is_leap(year_q));
        end
        SEL_DAY:  day_n = (day_q >= dim_cur) ? 8'd1 : day_q + 8'd1;
        default:  ;
      endcase
      // Pull the day back inside the new month so no illegal date is ever visible.
      if (sel != SEL_DAY && day_q > dim_new) day_n = dim_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      year_q     <= YRESET;
      month_q    <= MONTH_JAN;
      day_q      <= 8'd1;
      cout_day_q <= 1'b0;
      blink_q    <= 2'd0;
    end else begin
      year_q     <= year_n;
      month_q    <= month_n;
      day_q      <= day_n;
      cout_day_q <= cout_day;
      blink_q    <= sel;
    end
  end

  assign out_year  = year_q;
  assign out_month = month_q;
  assign out_day   = day_q;
  assign leap_year = is_leap(year_q);
  assign blink2    = blink_q;

endmodule
